pow4_accumulator: RTL and testbench

POW4_ACCUMULATOR -- requirements
Module: pow4_accumulator

---
 rtl/pow4_accumulator.sv | 149 ++++++++++++++
 tb/tb_pow4_accumulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pow4_accumulator.sv
// ============================================================================
// Module      : pow4_accumulator
// Description : Sums a^4 over SAMPLE_CNT unsigned 8-bit samples through a
//               3-stage pipeline and presents the result under a handshake.
//               Define POW4_ACC_SAT_EN for saturating accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pow4_accumulator #(
    parameter int SAMPLE_CNT = 16,
    parameter int ACC_W      = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [8:0] c_last_idx = 9'(SAMPLE_CNT - 1);

    state_t           r_state;
    logic [8:0]       r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_s1_valid;
    logic [7:0]       r_s1_data;
    logic             r_s2_valid;
    logic [31:0]      r_s2_pow;
    logic [ACC_W-1:0] r_acc;

    logic             w_accept;
    logic [15:0]      w_sq;
    logic [31:0]      w_pow;
    logic [ACC_W-1:0] w_pow_ext;

    assign w_accept  = in_valid & r_in_ready;
    assign w_sq      = {8'd0, r_s1_data} * {8'd0, r_s1_data};
    assign w_pow     = {16'd0, w_sq} * {16'd0, w_sq};
    assign w_pow_ext = {{(ACC_W-32){1'b0}}, r_s2_pow};

`ifdef POW4_ACC_SAT_EN
    // One extra bit exposes the carry that signals overflow.
    logic [ACC_W:0]   w_sum;
    logic             r_sat;
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_pow_ext};
    assign out_sat = r_sat;
`else
    logic [ACC_W-1:0] w_sum;
    assign w_sum   = r_acc + w_pow_ext;
    assign out_sat = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 8'd0;
            r_s2_valid <= 1'b0;
            r_s2_pow   <= 32'd0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_data  <= in_data;
            r_s2_valid <= r_s1_valid;
            r_s2_pow   <= w_pow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_count     <= 9'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
`ifdef POW4_ACC_SAT_EN
            r_sat       <= 1'b0;
`endif
        end else begin
            // S3 can only be busy in ACCUM/DRAIN, so it never collides with the clear in HOLD.
            if (r_s2_valid) begin
`ifdef POW4_ACC_SAT_EN
                if (w_sum[ACC_W]) begin
                    r_acc <= '1;
                    r_sat <= 1'b1;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                end
`else
                r_acc <= w_sum;
`endif
            end

            case (r_state)
                ST_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_count <= r_count + 9'd1;
                        if (r_count == c_last_idx) begin
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_in_ready <= 1'b0;
                    if (!r_s1_valid && !r_s2_valid) begin
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_count     <= 9'd0;
                        r_acc       <= '0;
`ifdef POW4_ACC_SAT_EN
                        r_sat       <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pow4_accumulator.sv
// ============================================================================
// Module      : tb_pow4_accumulator
// Description : Scoreboard bench; one 40-bit and one 33-bit instance share
//               the same stimulus (SAMPLE_CNT=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pow4_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        out_ready = 1'b1;

    logic        rdy40, v40, sat40;
    logic [39:0] sum40;
    logic        rdy33, v33, sat33;
    logic [32:0] sum33;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] e40;
        logic [63:0] e33;
        logic        s33;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    pow4_accumulator #(.SAMPLE_CNT(4), .ACC_W(40)) dut40 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy40), .out_valid(v40), .out_ready(out_ready),
        .out_sum(sum40), .out_sat(sat40)
    );

    pow4_accumulator #(.SAMPLE_CNT(4), .ACC_W(33)) dut33 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy33), .out_valid(v33), .out_ready(out_ready),
        .out_sum(sum33), .out_sat(sat33)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [63:0] e40, input logic [63:0] e33, input logic s33);
        exp_t e;
        e.e40 = e40;
        e.e33 = e33;
        e.s33 = s33;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!rdy40 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk);
        end
    endtask

    // Last accept at edge T: out_valid must read 0,0,0 then 1 after T+3.
    task automatic lat_check();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("lat_valid40", {63'd0, v40}, {63'd0, (k == 3)});
            chk("lat_valid33", {63'd0, v33}, {63'd0, (k == 3)});
            chk("lat_in_ready", {63'd0, rdy40}, 64'd0);
        end
    endtask

    task automatic drain_q();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(negedge clk);
        chk("ready_after_hs", {63'd0, rdy40}, 64'd1);
    endtask

    // Scoreboard monitor: compares whenever a result handshake is about to occur.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (v40 && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got sum %0d expected none", sum40);
                end else begin
                    e = q.pop_front();
                    chk("sum40", {24'd0, sum40}, e.e40);
                    chk("sat40", {63'd0, sat40}, 64'd0);
                    chk("valid33", {63'd0, v33}, 64'd1);
                    chk("sum33", {31'd0, sum33}, e.e33);
                    chk("sat33", {63'd0, sat33}, {63'd0, e.s33});
                end
            end
        end
    end

    initial begin
        int n;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, rdy40}, 64'd0);
        chk("rst_out_valid", {63'd0, v40}, 64'd0);
        chk("rst_out_sum", {24'd0, sum40}, 64'd0);
        chk("rst_out_sat", {63'd0, sat33}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {63'd0, rdy40}, 64'd1);

        // 1,2,3,4 back-to-back
        push(64'd354, 64'd354, 1'b0);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        lat_check();
        drain_q();

        // four samples of 255: wraps or clamps in the 33-bit instance
`ifdef POW4_ACC_SAT_EN
        push(64'd16913002500, 64'd8589934591, 1'b1);
`else
        push(64'd16913002500, 64'd8323067908, 1'b0);
`endif
        for (int i = 0; i < 4; i++) send(8'd255);
        lat_check();
        drain_q();

        // Back-pressure in HOLD
        out_ready = 1'b0;
        push(64'd324, 64'd324, 1'b0);
        for (int i = 0; i < 4; i++) send(8'd3);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!v40 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", {63'd0, v40}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'd9;
            chk("hold_valid", {63'd0, v40}, 64'd1);
            chk("hold_sum", {24'd0, sum40}, 64'd324);
            chk("hold_in_ready", {63'd0, rdy40}, 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_in_ready", {63'd0, rdy40}, 64'd1);
        chk("hs_out_valid", {63'd0, v40}, 64'd0);
        push(64'd4, 64'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(8'd1);
        lat_check();
        drain_q();

        // in_valid toggling 1,0,1,0 with data 2
        push(64'd64, 64'd64, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_data  = 8'd2;
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain_q();

        // Reset mid-operation
        send(8'd7); send(8'd7);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {63'd0, rdy40}, 64'd0);
        chk("midrst_out_sum", {24'd0, sum40}, 64'd0);
        chk("midrst_out_valid", {63'd0, v33}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        push(64'd4, 64'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(8'd1);
        lat_check();
        drain_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
